compuertas_param_seq: RTL
=========================

// Module: compuertas_param_seq
// PURPOSE
//  Parametrised, registered successor to the 3-input gate block. Applies one of 8 bitwise
//  logic ops to WIDTH-bit operands, with a valid/ready handshake on both sides.
//  Two modes:
//   - direct: one result per beat.
//   - accumulate: folds a burst of operands into one result; the burst may be any length.
//  Each result comes with its XOR-reduction parity. Sits between operand producers and
//  downstream datapath logic.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=1)
//  CNT_W   8   width of the burst beat counter (>=1); counter saturates
// PORTS
//  clk         in   1        single clock, rising edge
//  rst         in   1        synchronous reset, active-high
//  in_valid    in   1        input beat present
//  in_ready    out  1        block can accept a beat
//  in_a        in   WIDTH    operand A
//  in_b        in   WIDTH    operand B (ignored in accumulate mode)
//  in_op       in   3        0 AND, 1 OR, 2 NOT, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 PASS
//  in_acc      in   1        0 = direct, 1 = accumulate
//  in_first    in   1        accumulate: first beat of burst
//  in_last     in   1        accumulate: last beat of burst
//  out_valid   out  1        result present
//  out_ready   in   1        consumer accepts result
//  out_data    out  WIDTH    result
//  out_parity  out  1        ^out_data
//  out_count   out  CNT_W    beats folded into result (1 in direct mode)
//  abort       out  1        1-cycle pulse: an open burst was discarded
// BEHAVIOUR
//  Reset: sync, active-high, one clock.
//   - Clears out_valid, out_data, out_parity, out_count, abort, acc and cnt to 0.
//   - state = IDLE.
//   - Asserting rst mid-burst discards the burst silently; abort does NOT pulse.
//  Handshake:
//   - Beat accepted when in_valid && in_ready.
//   - Result consumed when out_valid && out_ready.
//   - in_ready = !out_valid || out_ready (combinational). Full throughput with no bubbles.
//   - out_* hold stable while out_valid && !out_ready.
//  Op f(x,y): x&y, x|y, ~x, ~(x&y), ~(x|y), x^y, ~(x^y), x.
//   - All ops are bitwise over WIDTH bits.
//   - NOT and PASS ignore y.
//  Direct mode (in_acc=0):
//   - Accepted beat -> next edge: out_data = f(in_a, in_b), out_count = 1, out_valid = 1.
//   - Latency 1 cycle.
//  Accumulate mode (in_acc=1):
//   - The op is sampled on every beat.
//   - x = acc, y = in_a, except on seeding beats, where acc = in_a.
//   - States:
//     - IDLE: no burst open.
//     - ACCUM: burst open; acc and cnt valid.
//   - IDLE + beat: seeding beat. Any beat in IDLE seeds, even with in_first = 0.
//     - acc = in_a, cnt = 1.
//     - in_last = 0 -> ACCUM.
//     - in_last = 1 -> emit acc/cnt next edge, stay IDLE.
//   - ACCUM + beat, in_first = 0:
//     - acc = f(acc, in_a), cnt = sat(cnt+1).
//     - in_last = 1 -> emit and go to IDLE.
//   - ACCUM + beat, in_first = 1: restart.
//     - Partial burst discarded; abort pulses next cycle.
//     - The beat seeds a new burst: in_last = 0 -> stay ACCUM; in_last = 1 -> emit, go IDLE.
//   - ACCUM + direct beat (in_acc = 0):
//     - Burst discarded; abort pulses next cycle; go to IDLE.
//     - The direct result is still emitted normally.
//   - Emit latency: 1 cycle after the last beat is accepted.
//   - No output is produced for non-last beats. in_ready stays 1 while no result is pending.
//  Counter: cnt saturates at 2^CNT_W-1 and never wraps. acc keeps folding after saturation.
//  Parity: out_parity is registered together with out_data; it always equals ^out_data.
//  Idle beats: cycles with in_valid = 0 leave state, acc and cnt unchanged.
// TESTING
//  T1 reset: assert rst 2 cycles mid-burst (WIDTH=8) -> all outputs 0, IDLE, no abort pulse.
//  T2 direct: a=8'hF0, b=8'h3C, op sweep 0..7 back to back with out_ready=1
//     -> results in order: 30, FC, 0F, CF, 03, CC, 33, F0; one per cycle; parity matches.
//  T3 accum XOR: burst A5, 0F, FF (first on beat 1, last on beat 3)
//     -> single result 8'h55, count 3, parity 0.
//  T4 backpressure: out_ready=0 for 5 cycles with result pending
//     -> in_ready=0, out_data held; release -> resumes with no beat lost or duplicated.
//  T5 restart/abort: open AND burst, then a beat with first=1, then a direct beat
//     -> abort pulses twice; direct result is correct; state ends IDLE.
//  T6 saturation: CNT_W=2, 6-beat OR burst -> out_count=3, data = OR of all 6 beats.

Source files
------------

// File: rtl/compuertas_param_seq.sv
// Registered, parametrised gate block: eight bitwise ops over WIDTH-bit operands.
// Direct mode gives one result per beat. Accumulate mode folds a burst into one result.
// Both sides use valid/ready handshakes.

// One bit of the gate datapath: z = f(x, y) for the selected op.
module compuertasLane (
    input  logic       x,
    input  logic       y,
    input  logic [2:0] op,
    output logic       z
);
    // Bitwise op select; NOT and PASS ignore y.
    always_comb begin
        z = 1'b0;
        unique case (op)
            3'd0: z = x & y;
            3'd1: z = x | y;
            3'd2: z = ~x;
            3'd3: z = ~(x & y);
            3'd4: z = ~(x | y);
            3'd5: z = x ^ y;
            3'd6: z = ~(x ^ y);
            3'd7: z = x;
            default: z = 1'b0;
        endcase
    end
endmodule

module compuertas_param_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_count,
    output logic             abort
);
    typedef enum logic {IDLE, ACCUM} state_t;

    state_t           state, stateNext;
    logic [WIDTH-1:0] acc, accNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [WIDTH-1:0] opX, opY, opRes;
    logic [WIDTH-1:0] emitData;
    logic [CNT_W-1:0] emitCount;
    logic             emit, abortNext, accept;

    // The output register is free, or is being drained this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // One gate datapath is shared by both modes: direct uses (a, b); folding uses (acc, a).
    assign opX = in_acc ? acc  : in_a;
    assign opY = in_acc ? in_a : in_b;

    for (genvar i = 0; i < WIDTH; i++) begin : gLane
        compuertasLane uLane (.x(opX[i]), .y(opY[i]), .op(in_op), .z(opRes[i]));
    end

    // Next-state, accumulator and emit decode for an accepted beat.
    always_comb begin
        stateNext = state;
        accNext   = acc;
        cntNext   = cnt;
        emit      = 1'b0;
        emitData  = '0;
        emitCount = '0;
        abortNext = 1'b0;
        if (accept) begin
            if (!in_acc) begin
                // A direct beat always emits; it kills any open burst.
                emit      = 1'b1;
                emitData  = opRes;
                emitCount = CNT_W'(1);
                abortNext = (state == ACCUM);
                stateNext = IDLE;
            end else if (state == IDLE || in_first) begin
                // Seeding beat. In IDLE every beat seeds, whatever in_first says.
                abortNext = (state == ACCUM);
                accNext   = in_a;
                cntNext   = CNT_W'(1);
                if (in_last) begin
                    emit      = 1'b1;
                    emitData  = in_a;
                    emitCount = CNT_W'(1);
                    stateNext = IDLE;
                end else begin
                    stateNext = ACCUM;
                end
            end else begin
                // Fold into the open burst. The count sticks at all-ones.
                accNext = opRes;
                cntNext = (cnt == '1) ? cnt : cnt + CNT_W'(1);
                if (in_last) begin
                    emit      = 1'b1;
                    emitData  = opRes;
                    emitCount = cntNext;
                    stateNext = IDLE;
                end
            end
        end
    end

    // Burst state and accumulator. Reset drops an open burst without an abort pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            acc   <= accNext;
            cnt   <= cntNext;
        end
    end

    // Output register. It holds while stalled and clears valid once consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_parity <= 1'b0;
            out_count  <= '0;
            abort      <= 1'b0;
        end else begin
            abort <= abortNext;
            if (emit) begin
                out_valid  <= 1'b1;
                out_data   <= emitData;
                out_parity <= ^emitData;
                out_count  <= emitCount;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
